mcu_fsm: RTL and testbench

- Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback, driving all datapath selects, enables and ALU op codes.
- Decodes the opcode and function fields of the current instruction register (IR).
- Sits between the IR and the multicycle datapath: PC, memory, register file and ALU.

---
 rtl/mcu_fsm.sv | 256 +++++++++++++++++++++++++
 tb/tb_mcu_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mcu_fsm.sv
// Multicycle MIPS control unit: Moore sequencer for fetch/decode/execute/memory/writeback.
// Drives every datapath select, enable and ALU op code from the state and the IR opcode/function fields.
module mcu_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       Branch,
    output logic       BNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [4:0] ALUOP,
    output logic [1:0] PCSource,
    output logic [2:0] SEX,
    output logic [1:0] StoreX
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MR  = 4'd3,
        S_LWB = 4'd4,
        S_MW  = 4'd5,
        S_RX  = 4'd6,
        S_RWB = 4'd7,
        S_BR  = 4'd8,
        S_J   = 4'd9,
        S_JAL = 4'd10,
        S_JR  = 4'd11,
        S_IX  = 4'd12,
        S_IWB = 4'd13
    } state_t;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_LUI  = 5'd14;

    state_t state, state_nx;

    // R-type function field to ALU operation; variable shifts share the constant-shift ops.
    function automatic logic [4:0] rx_aluop(input logic [5:0] f);
        case (f)
            6'h20, 6'h21: rx_aluop = ALU_ADD;
            6'h22, 6'h23: rx_aluop = ALU_SUB;
            6'h24:        rx_aluop = ALU_AND;
            6'h25:        rx_aluop = ALU_OR;
            6'h26:        rx_aluop = ALU_XOR;
            6'h27:        rx_aluop = ALU_NOR;
            6'h2A:        rx_aluop = ALU_SLT;
            6'h2B:        rx_aluop = ALU_SLTU;
            6'h00, 6'h04: rx_aluop = ALU_SLL;
            6'h02, 6'h06: rx_aluop = ALU_SRL;
            6'h03, 6'h07: rx_aluop = ALU_SRA;
            default:      rx_aluop = ALU_ADD;
        endcase
    endfunction

    function automatic logic is_shamt_shift(input logic [5:0] f);
        is_shamt_shift = (f == 6'h00) || (f == 6'h02) || (f == 6'h03);
    endfunction

    function automatic logic [4:0] ix_aluop(input logic [5:0] op);
        case (op)
            6'h0A:   ix_aluop = ALU_SLT;
            6'h0B:   ix_aluop = ALU_SLTU;
            6'h0C:   ix_aluop = ALU_AND;
            6'h0D:   ix_aluop = ALU_OR;
            6'h0E:   ix_aluop = ALU_XOR;
            6'h0F:   ix_aluop = ALU_LUI;
            default: ix_aluop = ALU_ADD;
        endcase
    endfunction

    // Logical immediates and lui take the zero-extended immediate.
    function automatic logic ix_zext(input logic [5:0] op);
        ix_zext = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E) || (op == 6'h0F);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        is_store = (op == 6'h2B) || (op == 6'h28) || (op == 6'h29);
    endfunction

    function automatic logic [2:0] sex_of(input logic [5:0] op);
        case (op)
            6'h20:   sex_of = 3'd1;
            6'h24:   sex_of = 3'd2;
            6'h21:   sex_of = 3'd3;
            6'h25:   sex_of = 3'd4;
            default: sex_of = 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] storex_of(input logic [5:0] op);
        case (op)
            6'h28:   storex_of = 2'd1;
            6'h29:   storex_of = 2'd2;
            default: storex_of = 2'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IF;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx    = S_IF;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        Branch      = 1'b0;
        BNE         = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 2'd0;
        RegDst      = 2'd0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 3'd0;
        ALUOP       = ALU_ADD;
        PCSource    = 2'd0;
        SEX         = 3'd0;
        StoreX      = 2'd0;

        case (state)
            S_IF: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                PCWrite  = 1'b1;
                ALUSrcB  = 3'd1;
                state_nx = S_ID;
            end
            // Decode cycle also precomputes the branch target into ALUOut.
            S_ID: begin
                ALUSrcB = 3'd3;
                case (Op)
                    6'h00:                      state_nx = (Funct == 6'h08) ? S_JR : S_RX;
                    6'h23, 6'h20, 6'h24, 6'h21,
                    6'h25, 6'h2B, 6'h28, 6'h29: state_nx = S_MA;
                    6'h04, 6'h05:               state_nx = S_BR;
                    6'h02:                      state_nx = S_J;
                    6'h03:                      state_nx = S_JAL;
                    6'h08, 6'h09, 6'h0A, 6'h0B,
                    6'h0C, 6'h0D, 6'h0E, 6'h0F: state_nx = S_IX;
                    default:                    state_nx = S_IF;
                endcase
            end
            S_MA: begin
                ALUSrcA  = 2'd1;
                ALUSrcB  = 3'd2;
                state_nx = is_store(Op) ? S_MW : S_MR;
            end
            S_MR: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
                SEX      = sex_of(Op);
                state_nx = S_LWB;
            end
            S_LWB: begin
                MemtoReg = 2'd1;
                RegWrite = 1'b1;
                SEX      = sex_of(Op);
            end
            S_MW: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                StoreX   = storex_of(Op);
            end
            S_RX: begin
                ALUSrcA  = is_shamt_shift(Funct) ? 2'd2 : 2'd1;
                ALUOP    = rx_aluop(Funct);
                state_nx = S_RWB;
            end
            S_RWB: begin
                RegDst   = 2'd1;
                RegWrite = 1'b1;
            end
            S_BR: begin
                ALUSrcA     = 2'd1;
                ALUOP       = ALU_SUB;
                PCSource    = 2'd1;
                PCWriteCond = 1'b1;
                Branch      = 1'b1;
                BNE         = (Op == 6'h05);
            end
            S_J: begin
                PCSource = 2'd2;
                PCWrite  = 1'b1;
            end
            // PC already holds PC+4 from fetch, so it is the link value.
            S_JAL: begin
                PCSource = 2'd2;
                PCWrite  = 1'b1;
                RegDst   = 2'd2;
                MemtoReg = 2'd2;
                RegWrite = 1'b1;
            end
            S_JR: begin
                PCSource = 2'd3;
                PCWrite  = 1'b1;
            end
            S_IX: begin
                ALUSrcA  = 2'd1;
                ALUSrcB  = ix_zext(Op) ? 3'd4 : 3'd2;
                ALUOP    = ix_aluop(Op);
                state_nx = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            default: state_nx = S_IF;
        endcase

        // Reset masks every control output, not just the state.
        if (!rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            Branch      = 1'b0;
            BNE         = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemtoReg    = 2'd0;
            RegDst      = 2'd0;
            ALUSrcA     = 2'd0;
            ALUSrcB     = 3'd0;
            ALUOP       = 5'd0;
            PCSource    = 2'd0;
            SEX         = 3'd0;
            StoreX      = 2'd0;
        end
    end

endmodule

// File: tb/tb_mcu_fsm.sv
// Directed bench for mcu_fsm: walks each instruction class cycle by cycle and
// compares the full control word against hand-written expectations.
module tb_mcu_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, PCWriteCond, Branch, BNE, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] MemtoReg, RegDst, ALUSrcA, PCSource, StoreX;
    logic [2:0] ALUSrcB, SEX;
    logic [4:0] ALUOP;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       Branch;
        logic       BNE;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegWrite;
        logic [1:0] MemtoReg;
        logic [1:0] RegDst;
        logic [1:0] ALUSrcA;
        logic [2:0] ALUSrcB;
        logic [4:0] ALUOP;
        logic [1:0] PCSource;
        logic [2:0] SEX;
        logic [1:0] StoreX;
    } ctl_t;

    ctl_t act;
    int   nerr = 0;
    int   nchk = 0;

    mcu_fsm dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .BNE(BNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOP(ALUOP), .PCSource(PCSource), .SEX(SEX), .StoreX(StoreX)
    );

    always_comb begin
        act             = '0;
        act.PCWrite     = PCWrite;
        act.PCWriteCond = PCWriteCond;
        act.Branch      = Branch;
        act.BNE         = BNE;
        act.IorD        = IorD;
        act.MemRead     = MemRead;
        act.MemWrite    = MemWrite;
        act.IRWrite     = IRWrite;
        act.RegWrite    = RegWrite;
        act.MemtoReg    = MemtoReg;
        act.RegDst      = RegDst;
        act.ALUSrcA     = ALUSrcA;
        act.ALUSrcB     = ALUSrcB;
        act.ALUOP       = ALUOP;
        act.PCSource    = PCSource;
        act.SEX         = SEX;
        act.StoreX      = StoreX;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input ctl_t exp);
        nchk++;
        assert (act === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic ctl_t c_if();
        ctl_t e = '0;
        e.PCWrite = 1'b1; e.IRWrite = 1'b1; e.MemRead = 1'b1; e.ALUSrcB = 3'd1;
        return e;
    endfunction

    function automatic ctl_t c_id();
        ctl_t e = '0;
        e.ALUSrcB = 3'd3;
        return e;
    endfunction

    // Expects IF now, then ID after one edge; leaves the bench in ID.
    task automatic fetch_decode(input string tag);
        chk({tag, "_if"}, c_if());
        tick();
        chk({tag, "_id"}, c_id());
    endtask

    initial begin
        ctl_t e;
        rst = 1'b0; Op = 6'h23; Funct = 6'h00;
        #3;
        chk("rst_zero", '0);
        tick(); tick();
        Op = 6'h00;
        chk("rst_held", '0);

        // add: IF ID RX RWB IF
        Funct = 6'h20;
        rst = 1'b1;
        #1;
        fetch_decode("add");
        tick(); e = '0; e.ALUSrcA = 2'd1; chk("add_rx", e);
        tick(); e = '0; e.RegDst = 2'd1; e.RegWrite = 1'b1; chk("add_rwb", e);
        tick();

        // lb: five cycles
        Op = 6'h20;
        fetch_decode("lb");
        tick(); e = '0; e.ALUSrcA = 2'd1; e.ALUSrcB = 3'd2; chk("lb_ma", e);
        tick(); e = '0; e.IorD = 1'b1; e.MemRead = 1'b1; e.SEX = 3'd1; chk("lb_mr", e);
        tick(); e = '0; e.MemtoReg = 2'd1; e.RegWrite = 1'b1; e.SEX = 3'd1; chk("lb_lwb", e);
        tick();

        // sh
        Op = 6'h29;
        fetch_decode("sh");
        tick(); e = '0; e.ALUSrcA = 2'd1; e.ALUSrcB = 3'd2; chk("sh_ma", e);
        tick(); e = '0; e.MemWrite = 1'b1; e.IorD = 1'b1; e.StoreX = 2'd2; chk("sh_mw", e);
        tick();

        // bne / beq
        Op = 6'h05;
        fetch_decode("bne");
        tick();
        e = '0; e.ALUSrcA = 2'd1; e.ALUOP = 5'd1; e.PCSource = 2'd1;
        e.PCWriteCond = 1'b1; e.Branch = 1'b1; e.BNE = 1'b1;
        chk("bne_br", e);
        tick();
        Op = 6'h04;
        fetch_decode("beq");
        tick(); e.BNE = 1'b0; chk("beq_br", e);
        tick();

        // jal
        Op = 6'h03;
        fetch_decode("jal");
        tick();
        e = '0; e.PCWrite = 1'b1; e.PCSource = 2'd2; e.RegDst = 2'd2;
        e.MemtoReg = 2'd2; e.RegWrite = 1'b1;
        chk("jal_x", e);
        tick();

        // jr
        Op = 6'h00; Funct = 6'h08;
        fetch_decode("jr");
        tick(); e = '0; e.PCWrite = 1'b1; e.PCSource = 2'd3; chk("jr_x", e);
        tick();

        // unknown opcode: ID straight back to IF
        Op = 6'h3F;
        fetch_decode("nop");
        tick(); chk("nop_back_if", c_if());

        // sll
        Op = 6'h00; Funct = 6'h00;
        tick(); chk("sll_id", c_id());
        tick(); e = '0; e.ALUSrcA = 2'd2; e.ALUOP = 5'd8; chk("sll_rx", e);
        tick(); e = '0; e.RegDst = 2'd1; e.RegWrite = 1'b1; chk("sll_rwb", e);
        tick();

        // srav uses register shift amount
        Funct = 6'h07;
        fetch_decode("srav");
        tick(); e = '0; e.ALUSrcA = 2'd1; e.ALUOP = 5'd10; chk("srav_rx", e);
        tick(); tick();

        // lui
        Op = 6'h0F;
        fetch_decode("lui");
        tick(); e = '0; e.ALUSrcA = 2'd1; e.ALUSrcB = 3'd4; e.ALUOP = 5'd14; chk("lui_ix", e);
        tick(); e = '0; e.RegWrite = 1'b1; chk("lui_iwb", e);
        tick();

        // sltiu with sign-extended immediate
        Op = 6'h0B;
        fetch_decode("sltiu");
        tick(); e = '0; e.ALUSrcA = 2'd1; e.ALUSrcB = 3'd2; e.ALUOP = 5'd7; chk("sltiu_ix", e);
        tick(); tick();

        // sub, then reset pulsed in RX
        Op = 6'h00; Funct = 6'h22;
        fetch_decode("sub");
        tick(); e = '0; e.ALUSrcA = 2'd1; e.ALUOP = 5'd1; chk("sub_rx", e);
        #2 rst = 1'b0;
        #1 chk("mid_rst_zero", '0);
        tick(); chk("mid_rst_held", '0);
        rst = 1'b1;
        #1 chk("resume_if", c_if());
        tick(); chk("resume_id", c_id());

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
